serial_sub_ctrl: RTL

Bit-serial N-bit subtractor controller. It sequences one single-bit subtract cell (x ^ y ^ bi difference, standard borrow) across WIDTH clock cycles, LSB first, under a start/busy/done handshake. It is the area-minimal alternative to the ripple-chain subtractor, for datapaths that can trade latency for gates. Results are held in output registers until the next operation completes.

---
 rtl/serial_sub_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one borrow cell stepped LSB first over WIDTH cycles,
// started by a start/busy/done handshake, with results held in output registers.
module serial_sub_ctrl #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] sd_r;
   logic             br_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] d_r;
   logic             bout_r;
   logic             zero_r;

   logic             dbit_s;
   logic             br_next_s;
   logic [WIDTH-1:0] sd_next_s;
   logic             last_s;

   function automatic logic sub_diff(input logic x, input logic y, input logic bi);
      return x ^ y ^ bi;
   endfunction

   function automatic logic sub_borrow(input logic x, input logic y, input logic bi);
      return (~x & (y | bi)) | (y & bi);
   endfunction

   // Single subtract cell on the current LSBs, plus the partial result with the new bit at the MSB.
   always_comb begin
      dbit_s    = sub_diff(sa_r[0], sb_r[0], br_r);
      br_next_s = sub_borrow(sa_r[0], sb_r[0], br_r);
      sd_next_s = {dbit_s, sd_r[WIDTH-1:1]};
      if (cnt_r == CW'(WIDTH - 1)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end

   // Control FSM with datapath shift registers and registered handshake/result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         sa_r    <= '0;
         sb_r    <= '0;
         sd_r    <= '0;
         br_r    <= 1'b0;
         cnt_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         d_r     <= '0;
         bout_r  <= 1'b0;
         zero_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
               done_r <= 1'b0;
               if (start) begin
                  sa_r    <= a;
                  sb_r    <= b;
                  sd_r    <= '0;
                  br_r    <= 1'b0;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               sa_r  <= sa_r >> 1;
               sb_r  <= sb_r >> 1;
               sd_r  <= sd_next_s;
               br_r  <= br_next_s;
               cnt_r <= cnt_r + CW'(1);
               if (last_s) begin
                  d_r     <= sd_next_s;
                  bout_r  <= br_next_s;
                  zero_r  <= (sd_next_s == '0);
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= RUN;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign d    = d_r;
   assign bout = bout_r;
   assign zero = zero_r;

endmodule
